// File: rtl/qpsk_tx_mapper_if.sv
// rtl/qpsk_tx_mapper_if.sv - 32-bit stream handshake bundle (tdata/tlast/tvalid/tready) for qpsk_tx_mapper
interface qpsk_tx_mapper_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/qpsk_tx_mapper.sv
// rtl/qpsk_tx_mapper.sv - QPSK dibit mapper holding each symbol SPS samples; QPSK_TX_DIFF_EN enables differential encoding
module qpsk_tx_mapper #(
  parameter int          SPS = 16,
  parameter logic [15:0] AMP = 16'h2D41
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  qpsk_tx_mapper_if.slave  s_axis,
  qpsk_tx_mapper_if.master m_axis
);

  localparam logic [15:0] AMP_NEG  = ~AMP + 16'd1;
  localparam logic [7:0]  SMP_LAST = 8'(SPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_n;
  logic [31:0] word_q, word_n;
  logic        last_q, last_n;
  logic [3:0]  sym_q, sym_n;
  logic [7:0]  smp_q, smp_n;
  logic [31:0] data_q, data_n;
  logic        valid_q, valid_n;
  logic        tlast_q, tlast_n;
  logic        s_ready;
  logic        s_hs, m_hs;
  logic        sym_end, word_end;
  logic        present;
  logic [1:0]  dibit;
`ifdef QPSK_TX_DIFF_EN
  logic [1:0]  phase_q, phase_n, phase_base;
`endif

  // Build one {I,Q} sample from the two rail signs.
  function automatic logic [31:0] point(input logic i_neg, input logic q_neg);
    return {(i_neg ? AMP_NEG : AMP), (q_neg ? AMP_NEG : AMP)};
  endfunction

`ifdef QPSK_TX_DIFF_EN
  // Phase increment per dibit: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] phase_step(input logic [1:0] d);
    return {d[1], d[1] ^ d[0]};
  endfunction
`endif

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = tlast_q;

  // Next-state: word load, sample/symbol counting and output sample selection.
  always_comb begin
    state_n  = state_q;
    word_n   = word_q;
    last_n   = last_q;
    sym_n    = sym_q;
    smp_n    = smp_q;
    data_n   = data_q;
    valid_n  = valid_q;
    present  = 1'b0;
    dibit    = word_q[31:30];

    sym_end  = (smp_q == SMP_LAST);
    word_end = sym_end && (sym_q == 4'd15);
    m_hs     = (state_q == RUN) && m_axis.tready;
    s_ready  = !ce_rst && ((state_q == IDLE) || (word_end && m_axis.tready));
    s_hs     = s_ready && s_axis.tvalid;

    if (s_hs) begin
      // New word: either from IDLE or chained onto the last sample of the previous word.
      state_n = RUN;
      word_n  = s_axis.tdata;
      last_n  = s_axis.tlast;
      sym_n   = 4'd0;
      smp_n   = 8'd0;
      valid_n = 1'b1;
      dibit   = s_axis.tdata[31:30];
      present = 1'b1;
    end else if (m_hs) begin
      if (word_end) begin
        state_n = IDLE;
        valid_n = 1'b0;
      end else if (sym_end) begin
        sym_n   = sym_q + 4'd1;
        smp_n   = 8'd0;
        word_n  = {word_q[29:0], 2'b00};
        dibit   = word_q[29:28];
        present = 1'b1;
      end else begin
        smp_n   = smp_q + 8'd1;
      end
    end

    tlast_n = (state_n == RUN) && last_n && (sym_n == 4'd15) && (smp_n == SMP_LAST);

`ifdef QPSK_TX_DIFF_EN
    phase_base = (m_hs && word_end && last_q) ? 2'd0 : phase_q;
    phase_n    = phase_base;
    if (present) begin
      phase_n = phase_base + phase_step(dibit);
      data_n  = point(phase_n[1] ^ phase_n[0], phase_n[1]);
    end
`else
    if (present) begin
      data_n = point(dibit[1], dibit[0]);
    end
`endif
  end

  // State, counters and registered output sample.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      sym_q   <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_n;
      word_q  <= word_n;
      last_q  <= last_n;
      sym_q   <= sym_n;
      smp_q   <= smp_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      tlast_q <= tlast_n;
    end
  end

`ifdef QPSK_TX_DIFF_EN
  // Differential phase accumulator, cleared on reset and after a tlast word.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase_n;
    end
  end
`endif

endmodule

// File: tb/tb_qpsk_tx_mapper.sv
// tb/tb_qpsk_tx_mapper.sv - randomized self-checking bench for qpsk_tx_mapper against an expected-sample queue model
module tb_qpsk_tx_mapper;
  localparam int          SPS = 16;
  localparam logic [15:0] AMP = 16'h2D41;

  logic ce_clk = 1'b0;
  logic ce_rst = 1'b1;

  qpsk_tx_mapper_if s_axis ();
  qpsk_tx_mapper_if m_axis ();

  qpsk_tx_mapper #(.SPS(SPS), .AMP(AMP)) dut (
    .ce_clk (ce_clk),
    .ce_rst (ce_rst),
    .s_axis (s_axis),
    .m_axis (m_axis)
  );

  always #5 ce_clk = ~ce_clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [32:0] exp_q[$];
  bit          mon_en   = 1'b0;
  bit          rand_rdy = 1'b0;
  int          hs_cnt   = 0;
  int          mdl_phase = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] rail(input bit neg);
    int v;
    v = neg ? -int'(AMP) : int'(AMP);
    return 16'(v);
  endfunction

  // Expand a whole word into its expected sample list.
  task automatic push_word(input logic [31:0] w, input bit last);
    int d;
    bit i_neg, q_neg;
    int step_tbl [4];
    step_tbl = '{0, 1, 3, 2};
    for (int s = 0; s < 16; s++) begin
      d = int'((w >> (30 - 2 * s)) & 32'd3);
`ifdef QPSK_TX_DIFF_EN
      mdl_phase = (mdl_phase + step_tbl[d]) % 4;
      i_neg = (mdl_phase == 1) || (mdl_phase == 2);
      q_neg = (mdl_phase >= 2);
`else
      i_neg = (d >= 2);
      q_neg = (d % 2) == 1;
`endif
      for (int k = 0; k < SPS; k++)
        exp_q.push_back({(last && s == 15 && k == SPS - 1), rail(i_neg), rail(q_neg)});
    end
    if (last) mdl_phase = 0;
  endtask

  // Output monitor: compare every cycle, pop on handshake, enqueue on input acceptance.
  always @(negedge ce_clk) begin
    if (mon_en) begin
      check("s_tready", 64'(s_axis.tready),
            64'(!ce_rst && (exp_q.size() == 0 || (exp_q.size() == 1 && m_axis.tready))));
      if (exp_q.size() == 0) begin
        check("tvalid_idle", 64'(m_axis.tvalid), 64'(0));
        check("tlast_idle", 64'(m_axis.tlast), 64'(0));
      end else begin
        check("tvalid_run", 64'(m_axis.tvalid), 64'(1));
        check("sample", 64'({m_axis.tlast, m_axis.tdata}), 64'(exp_q[0]));
        if (m_axis.tready && !ce_rst) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
      if (ce_rst) begin
        exp_q.delete();
        mdl_phase = 0;
      end else if (s_axis.tvalid && s_axis.tready) begin
        push_word(s_axis.tdata, s_axis.tlast);
      end
    end
  end

  // Output back-pressure: always ready, or 50% random.
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge ce_clk);
      #1;
      m_axis.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_word(input logic [31:0] w, input bit last);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    s_axis.tdata  = w;
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    while (!done && t < 20000) begin
      @(negedge ce_clk);
      done = s_axis.tready;
      t++;
      @(posedge ce_clk);
      #1;
    end
    s_axis.tvalid = 1'b0;
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge ce_clk);
      #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge ce_clk);
    #1;
  endtask

  initial begin
    int t;
    int base;
    logic [31:0] w0, w1;

    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 32'hA5A5_5A5A;
    s_axis.tlast  = 1'b1;
    ce_rst = 1'b1;
    repeat (3) begin
      @(negedge ce_clk);
      check("rst_tvalid", 64'(m_axis.tvalid), 64'(0));
      check("rst_tlast", 64'(m_axis.tlast), 64'(0));
      check("rst_tdata", 64'(m_axis.tdata), 64'(0));
      check("rst_tready", 64'(s_axis.tready), 64'(0));
    end
    @(posedge ce_clk);
    #1;
    ce_rst = 1'b0;
    s_axis.tvalid = 1'b0;
    @(negedge ce_clk);
    check("post_rst_tready", 64'(s_axis.tready), 64'(1));
    check("post_rst_tvalid", 64'(m_axis.tvalid), 64'(0));
    mon_en = 1'b1;
    @(posedge ce_clk);
    #1;

    send_word(32'h1B1B_1B1B, 1'b0);
    wait_drain();

    w0 = $urandom;
    w1 = $urandom;
    send_word(w0, 1'b0);
    send_word(w1, 1'b1);
    wait_drain();

    rand_rdy = 1'b1;
    send_word(w0, 1'b0);
    send_word(w1, 1'b1);
    wait_drain();

    for (int i = 0; i < 4; i++) begin
      rand_rdy = 1'($urandom_range(0, 1));
      send_word($urandom, 1'($urandom_range(0, 1)));
    end
    send_word(32'h5555_5555, 1'b1);
    wait_drain();
    rand_rdy = 1'b0;

    send_word(32'h5555_5555, 1'b1);
    send_word(32'h5555_5555, 1'b1);
    wait_drain();

    base = hs_cnt;
    send_word($urandom, 1'b1);
    t = 0;
    while (hs_cnt < base + 100 && t < 2000) begin
      @(posedge ce_clk);
      #1;
      t++;
    end
    check("mid_word_reach", 64'(hs_cnt >= base + 100), 64'(1));
    ce_rst = 1'b1;
    @(posedge ce_clk);
    #1;
    ce_rst = 1'b0;
    @(negedge ce_clk);
    check("after_rst_tvalid", 64'(m_axis.tvalid), 64'(0));
    check("after_rst_tlast", 64'(m_axis.tlast), 64'(0));
    @(posedge ce_clk);
    #1;
    base = hs_cnt;
    send_word($urandom, 1'b1);
    wait_drain();
    check("post_rst_word_len", 64'(hs_cnt - base), 64'(16 * SPS));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qpsk_tx_mapper.md
# qpsk_tx_mapper

Transmit-side QPSK baseband modulator for the RFNoC QPSK block. It accepts packed payload bits on a 32-bit AXI-stream and maps each dibit to a QPSK constellation point. Each symbol is held for SPS samples and emitted as 32-bit {I,Q} sc16 samples, so the receiver chain (Costas loop plus bit sync at 16 samples/symbol) can recover them. It sits between the axi_wrapper `m_axis_data` port and the `s_axis_data` port of a TX noc_block, with packet framing preserved via tlast.

## Interface
- SPS, 16, samples per symbol; legal range 2..256.
- AMP, 16'h2D41 (11585 ≈ 0.707·2^14), constellation magnitude per rail, signed positive.
- ce_clk  in  1  block clock; all logic on rising edge.
- ce_rst  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  32  payload word; 16 dibits, MSB dibit [31:30] transmitted first.
- s_axis_tlast  in  1  last word of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  sample {I[31:16], Q[15:0]}, two's complement.
- m_axis_tlast  out  1  last sample of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

## Operation
- Two states: IDLE (no word held) and RUN (word held in shift register, symbol index sym 0..15, sample counter smp 0..SPS-1).
- IDLE: s_axis_tready=1; on s_axis handshake load word and tlast flag, sym=0, smp=0, go RUN, present symbol 0.
- RUN: m_axis_tvalid=1. Each m_axis handshake increments smp. At smp=SPS-1, smp wraps to 0 and sym increments (shift word left 2). At sym=15 & smp=SPS-1 the word is done.
- Word done with s_axis_tvalid=1: load the next word in the same cycle and stay RUN (no bubble). Word done without input: go IDLE, m_axis_tvalid=0.
- s_axis_tready = ~ce_rst & (IDLE | (sym=15 & smp=SPS-1 & m_axis_tready)).
- Mapping, dibit b1b0: b1 selects I sign, b0 selects Q sign (0→+AMP, 1→−AMP). 00=(+,+), 01=(+,−), 10=(−,+), 11=(−,−). −AMP is the 16-bit two's complement; AMP=0x2D41 gives 0xD2BF.
- m_axis_tlast=1 only on sym=15, smp=SPS-1 of a word loaded with tlast=1.
- Output is stable (data, last) while m_axis_tvalid=1 & m_axis_tready=0.
- Reset mid-word: the word is discarded, no tlast is emitted, state is IDLE.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0 during reset and 1 the cycle after.
- Latency: a word accepted on cycle N presents its first sample with m_axis_tvalid=1 on cycle N+1.
- m_axis_tdata, m_axis_tvalid and m_axis_tlast are registered. s_axis_tready is combinational from state and m_axis_tready; there is no combinational path from s_axis_tvalid to any output.
- Throughput with m_axis_tready=1: exactly 16·SPS samples per word, continuous across back-to-back words.
- Counters advance only on m_axis handshakes.

## Configuration
- QPSK_TX_DIFF_EN defined: differential encoding. A 2-bit phase register p advances modulo 4 on each symbol by a dibit-dependent step: 00→+0, 01→+1, 11→+2, 10→+3.
  - Phase to point: p=0 (+,+), 1 (−,+), 2 (−,−), 3 (+,−).
  - p resets to 0 on ce_rst and after the last symbol of a tlast word.
  - The new p is used for the symbol it is computed for. This removes the receiver Costas loop's 90° ambiguity.
- QPSK_TX_DIFF_EN undefined: direct Gray mapping as in Operation; no phase register.

## Test plan
- Reset: hold ce_rst 3 cycles with s_axis_tvalid=1 → all outputs 0, no word accepted; s_axis_tready=1 the cycle after release.
- Word 0x1B1B1B1B, tlast=0, m_axis_tready=1, SPS=16 → 256 samples. Samples 0–15 = 0x2D412D41, 16–31 = 0x2D41D2BF, 32–47 = 0xD2BF2D41, 48–63 = 0xD2BFD2BF, pattern repeats; tlast never asserted.
- Two words back-to-back, second tlast=1 → 512 contiguous valid samples, m_axis_tvalid never drops; tlast only on sample 511; s_axis_tready pulses on the cycles of samples 255 and 511.
- Random m_axis_tready (50%) on the previous stimulus → identical sample sequence; data and last held stable during every stall.
- QPSK_TX_DIFF_EN, word 0x55555555 tlast=1, then the same word again → first word phases 1,2,3,0 repeating: samples 0–15 = 0xD2BF2D41, 16–31 = 0xD2BFD2BF. Second word restarts at phase 1 (sample 0 = 0xD2BF2D41).
- Assert ce_rst at sample 100 of a word → next cycle m_axis_tvalid=0. The next word starts cleanly at sym 0 and emits a full 256 samples.
